vc_iter_mul_div: RTL and testbench

//  Parametrised iterative multiply/divide unit, the multi-cycle successor to the

---
 rtl/vc_iter_mul_div.sv | 205 ++++++++++++++++++++
 tb/tb_vc_iter_mul_div.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_iter_mul_div.sv
// Iterative shift-add multiplier / restoring divider, fixed latency.
// Define VC_MULDIV_SIGNED_EN to build signed DIV/REM sign handling.
module vc_iter_mul_div #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sd,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [2:0]         in_op,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_data
);

  localparam int N  = p_nbits;
  localparam int CW = $clog2(p_nbits) + 1;
  localparam logic [CW-1:0] LAST = CW'(p_nbits);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]  cnt;
  logic [N-1:0]   opa;
  logic [N-1:0]   opb;
  logic [2*N-1:0] prod;
  logic [N-1:0]   rem;
  logic [N-1:0]   quo;
  logic           op_mul;
  logic           op_hi;
  logic           op_rem;

  logic           dec_mul;
  logic           dec_hi;
  logic           dec_rem;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  logic [N-1:0]   mpp;
  logic [N:0]     msum;
  logic [2*N-1:0] prod_nx;
  logic [N:0]     shf;
  logic [N:0]     dif;
  logic [N-1:0]   rem_nx;
  logic [N-1:0]   quo_nx;
  logic [N-1:0]   q_fix;
  logic [N-1:0]   r_fix;
  logic [N-1:0]   res;

  logic           accept;
  logic           sd_unused;

  assign sd_unused = sd;
  assign accept    = in_val && in_rdy;

`ifdef VC_MULDIV_SIGNED_EN
  localparam logic [N-1:0] ONE = N'(1);

  logic qneg;
  logic rneg;
  logic bz;
  logic dec_sgn;

  function automatic logic [N-1:0] neg(
    input logic [N-1:0] x
  );
    return ~x + ONE;
  endfunction
`endif

  // Decode the request and form operand magnitudes.
  always_comb begin
    dec_mul = (in_op == 3'b000) ||
              (in_op == 3'b001) ||
              (in_op[2:1] == 2'b11);
    dec_hi  = (in_op == 3'b001);
    dec_rem = (in_op == 3'b011) ||
              (in_op == 3'b101);
    a_mag   = in_a;
    b_mag   = in_b;
`ifdef VC_MULDIV_SIGNED_EN
    dec_sgn = (in_op[2:1] == 2'b10);
    if (dec_sgn && in_a[N-1])
      a_mag = neg(in_a);
    if (dec_sgn && in_b[N-1])
      b_mag = neg(in_b);
`endif
  end

  // One multiply step and one division step.
  always_comb begin
    mpp     = prod[0] ? opa : '0;
    msum    = {1'b0, prod[2*N-1:N]} +
              {1'b0, mpp};
    prod_nx = {msum, prod[N-1:1]};
    shf     = {rem, quo[N-1]};
    dif     = shf - {1'b0, opb};
    rem_nx  = dif[N] ? shf[N-1:0]
                     : dif[N-1:0];
    quo_nx  = {quo[N-2:0], ~dif[N]};
    q_fix   = quo_nx;
    r_fix   = rem_nx;
`ifdef VC_MULDIV_SIGNED_EN
    if (qneg && !bz)
      q_fix = neg(quo_nx);
    if (rneg)
      r_fix = neg(rem_nx);
`endif
    if (op_mul)
      res = op_hi ? prod_nx[2*N-1:N]
                  : prod_nx[N-1:0];
    else
      res = op_rem ? r_fix : q_fix;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    out_val  = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val)
          state_nx = CALC;
      end
      CALC: begin
        if (cnt == LAST)
          state_nx = DONE;
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, iteration and result capture. The first CALC
  // cycle (cnt==0) seeds the datapath; the next N cycles each
  // retire one bit, so latency never depends on operand values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      opa      <= '0;
      opb      <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      op_mul   <= 1'b0;
      op_hi    <= 1'b0;
      op_rem   <= 1'b0;
      out_data <= '0;
`ifdef VC_MULDIV_SIGNED_EN
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      bz       <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      opa    <= a_mag;
      opb    <= b_mag;
      op_mul <= dec_mul;
      op_hi  <= dec_hi;
      op_rem <= dec_rem;
`ifdef VC_MULDIV_SIGNED_EN
      qneg   <= dec_sgn &&
                (in_a[N-1] ^ in_b[N-1]);
      rneg   <= dec_sgn && in_a[N-1];
      bz     <= (in_b == '0);
`endif
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (cnt == '0) begin
        prod <= {{N{1'b0}}, opb};
        rem  <= '0;
        quo  <= opa;
      end else begin
        prod <= prod_nx;
        rem  <= rem_nx;
        quo  <= quo_nx;
        if (cnt == LAST)
          out_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_vc_iter_mul_div.sv
// Self-checking bench for vc_iter_mul_div.
// Directed and random ops against an arithmetic reference model.
module tb_vc_iter_mul_div;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         sd;
  logic         in_val;
  logic         in_rdy;
  logic [2:0]   in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_val;
  logic         out_rdy;
  logic [N-1:0] out_data;

  int n_pass = 0;
  int n_tot  = 0;

  vc_iter_mul_div #(.p_nbits(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .sd       (sd),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] p;
    logic [31:0] r;
    int          sa;
    int          sb;
    p = 64'(a) * 64'(b);
    r = p[31:0];
    sa = a;
    sb = b;
    case (op)
      3'd1: r = p[63:32];
      3'd2, 3'd3: begin
        if (b == 0)
          r = (op == 3'd2) ? 32'hFFFF_FFFF : a;
        else
          r = (op == 3'd2) ? a / b : a % b;
      end
      3'd4, 3'd5: begin
        if (b == 0)
          r = (op == 3'd4) ? 32'hFFFF_FFFF : a;
`ifdef VC_MULDIV_SIGNED_EN
        else if (a == 32'h8000_0000 &&
                 b == 32'hFFFF_FFFF)
          r = (op == 3'd4) ? a : 32'd0;
        else
          r = (op == 3'd4) ? 32'(sa / sb)
                           : 32'(sa % sb);
`else
        else
          r = (op == 3'd4) ? a / b : a % b;
`endif
      end
      default: r = p[31:0];
    endcase
    return r;
  endfunction

  task automatic do_op(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          hold
  );
    logic [31:0] exp;
    int          n;
    exp = model(op, a, b);
    n = 0;
    while (!in_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdy_wait", 32'(in_rdy), 32'd1);
    in_op   = op;
    in_a    = a;
    in_b    = b;
    in_val  = 1'b1;
    out_rdy = (hold == 0);
    @(posedge clk); #1;
    in_val = 1'b0;
    in_op  = 3'($urandom);
    in_a   = $urandom;
    in_b   = $urandom;
    n = 0;
    while (!out_val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd33);
    for (int k = 0; k < hold; k++) begin
      chk("hold_val", 32'(out_val), 32'd1);
      chk("hold_data", out_data, exp);
      chk("hold_rdy", 32'(in_rdy), 32'd0);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    chk("data", out_data, exp);
    @(posedge clk); #1;
    chk("drain_val", 32'(out_val), 32'd0);
    chk("drain_rdy", 32'(in_rdy), 32'd1);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset   = 1'b1;
    sd      = 1'b0;
    in_val  = 1'b0;
    in_op   = 3'd0;
    in_a    = '0;
    in_b    = '0;
    out_rdy = 1'b1;
    #12;
    chk("rst_rdy", 32'(in_rdy), 32'd1);
    chk("rst_val", 32'(out_val), 32'd0);
    chk("rst_data", out_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op(3'd0, 32'd7, 32'd6, 0);
    do_op(3'd1, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'd100, 32'd7, 0);
    do_op(3'd3, 32'd100, 32'd7, 0);
    do_op(3'd2, 32'd5, 32'd0, 0);
    do_op(3'd3, 32'd5, 32'd0, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd4, 32'h8000_0000,
          32'hFFFF_FFFF, 0);
    do_op(3'd5, 32'h8000_0000,
          32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
    do_op(3'd5, 32'hFFFF_FFF9, 32'd0, 0);
    do_op(3'd6, 32'd12345, 32'd678, 0);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd3, 0);
    do_op(3'd0, 32'd123456789, 32'd987, 10);

    in_op  = 3'd0;
    in_a   = 32'd9;
    in_b   = 32'd9;
    in_val = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(in_rdy), 32'd1);
    chk("mid_rst_val", 32'(out_val), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(3'd3, 32'd1000, 32'd33, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0)
        rb = 32'd0;
      else if ($urandom_range(0, 3) == 0)
        rb = 32'($urandom_range(1, 40));
      do_op(rop, ra, rb,
            $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed",
             n_pass, n_tot);
    $finish;
  end

endmodule
